// File: rtl/intersection_scheduler_if.sv
// Signal bundle between the intersection scheduler and its environment.
// PREEMPT_EN adds the emergency preempt input (approach A).
interface intersection_scheduler_if;
  logic       req_a;
  logic       req_b;
`ifdef PREEMPT_EN
  logic       preempt;
`endif
  logic       a_r, a_y, a_g;
  logic       b_r, b_y, b_g;
  logic [2:0] phase;
  logic       tick;

  // scheduler side: samples demand, drives lamp state
  modport master (
`ifdef PREEMPT_EN
    input  preempt,
`endif
    input  req_a, req_b,
    output a_r, a_y, a_g, b_r, b_y, b_g, phase, tick
  );

  // environment side: raises demand, observes lamps
  modport slave (
`ifdef PREEMPT_EN
    output preempt,
`endif
    output req_a, req_b,
    input  a_r, a_y, a_g, b_r, b_y, b_g, phase, tick
  );
endinterface

// File: rtl/intersection_scheduler.sv
// Two-approach phase ring scheduler (A green -> A yellow -> all red ->
// B green -> B yellow -> all red). Demand-driven green between GREEN_MIN
// and GREEN_MAX ticks; tick comes from a free-running prescaler.
// Optional feature macro: PREEMPT_EN (emergency preempt for approach A).
module intersection_scheduler #(
  parameter int TICK_DIV  = 128,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int TMR_W     = 5
) (
  input logic clk,
  input logic rst,
  intersection_scheduler_if.master io
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [TMR_W-1:0] GMIN_M1  = TMR_W'(GREEN_MIN - 1);
  localparam logic [TMR_W-1:0] GMAX_M1  = TMR_W'(GREEN_MAX - 1);
  localparam logic [TMR_W-1:0] YEL_M1   = TMR_W'(YELLOW_T - 1);
  localparam logic [TMR_W-1:0] AR_M1    = TMR_W'(ALLRED_T - 1);

  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALLRED_AB = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALLRED_BA = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer;
  logic [PRE_W-1:0]   pre;
  logic               pend_a, pend_b;
  logic               tick;
  logic               exit_ok;
  logic               pre_em;

`ifdef PREEMPT_EN
  assign pre_em = io.preempt;
`else
  assign pre_em = 1'b0;
`endif

  assign tick = (pre == PRE_LAST);

  // state, phase timer, prescaler and pending-demand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= A_GREEN;
      timer  <= '0;
      pre    <= '0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
    end else begin
      state <= state_nxt;
      pre   <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        if (exit_ok)
          timer <= '0;
        else if (!(state == A_GREEN && timer == GMAX_M1))
          timer <= timer + 1'b1;  // held at GREEN_MAX-1 only while preempt blocks A exit
      end
      // clearing on entry to own green takes priority over a new request
      if (state_nxt == A_GREEN && state != A_GREEN) pend_a <= 1'b0;
      else if (io.req_a && state != A_GREEN)        pend_a <= 1'b1;
      if (state_nxt == B_GREEN && state != B_GREEN) pend_b <= 1'b0;
      else if (io.req_b && state != B_GREEN)        pend_b <= 1'b1;
    end
  end

  // exit condition for the current phase and ring advance on tick
  always_comb begin
    exit_ok   = 1'b0;
    state_nxt = state;
    case (state)
      A_GREEN:            exit_ok = !pre_em &&
                                    (((timer >= GMIN_M1) && pend_b) || (timer == GMAX_M1));
      B_GREEN:            exit_ok = pre_em ||
                                    ((timer >= GMIN_M1) && pend_a) || (timer == GMAX_M1);
      A_YELLOW, B_YELLOW: exit_ok = (timer == YEL_M1);
      default:            exit_ok = (timer == AR_M1);
    endcase
    if (tick && exit_ok) begin
      case (state)
        A_GREEN:   state_nxt = A_YELLOW;
        A_YELLOW:  state_nxt = ALLRED_AB;
        ALLRED_AB: state_nxt = B_GREEN;
        B_GREEN:   state_nxt = B_YELLOW;
        B_YELLOW:  state_nxt = ALLRED_BA;
        default:   state_nxt = A_GREEN;
      endcase
    end
  end

  // Moore lamp decode: exactly one lamp per approach, never both non-red
  always_comb begin
    io.a_r = 1'b0; io.a_y = 1'b0; io.a_g = 1'b0;
    io.b_r = 1'b0; io.b_y = 1'b0; io.b_g = 1'b0;
    case (state)
      A_GREEN:  begin io.a_g = 1'b1; io.b_r = 1'b1; end
      A_YELLOW: begin io.a_y = 1'b1; io.b_r = 1'b1; end
      B_GREEN:  begin io.a_r = 1'b1; io.b_g = 1'b1; end
      B_YELLOW: begin io.a_r = 1'b1; io.b_y = 1'b1; end
      default:  begin io.a_r = 1'b1; io.b_r = 1'b1; end
    endcase
    io.phase = state;
    io.tick  = tick;
  end

endmodule
